// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer: access-type codes,
// FSM state encoding and access-size decoding.
package mem_pkg;

   localparam logic [2:0] MT_LW  = 3'd0;
   localparam logic [2:0] MT_LH  = 3'd1;
   localparam logic [2:0] MT_LHU = 3'd2;
   localparam logic [2:0] MT_LB  = 3'd3;
   localparam logic [2:0] MT_LBU = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_FIN,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      SZ_WORD,
      SZ_HALF,
      SZ_BYTE
   } size_t;

   // Codes 5..7 fall through to word.
   function automatic size_t decode_size(input logic [2:0] mt);
      case (mt)
         MT_LH, MT_LHU: decode_size = SZ_HALF;
         MT_LB, MT_LBU: decode_size = SZ_BYTE;
         default:       decode_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
module load_extract (
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  mem_type,
   output logic [31:0] result
);
   import mem_pkg::*;

   logic [15:0] half;
   logic [7:0]  byte_v;

   always_comb begin
      half = offset[1] ? word[31:16] : word[15:0];
      case (offset)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      case (mem_type)
         MT_LH:   result = {{16{half[15]}}, half};
         MT_LHU:  result = {16'h0000, half};
         MT_LB:   result = {{24{byte_v[7]}}, byte_v};
         MT_LBU:  result = {24'h000000, byte_v};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: alignment check, registered memory request
// with byte enables, ack/timeout handling and extended load return.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  mem_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   import mem_pkg::*;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state, state_next;
   logic [7:0]  cnt;
   logic        is_store_q;
   logic [2:0]  type_q;
   logic [1:0]  off_q;
   logic        err_to;
   size_t       size_in;
   logic        misaligned;
   logic [3:0]  be_in;
   logic [31:0] wd_in;
   logic [31:0] ext;

   load_extract u_ext (
      .word     (mem_rdata),
      .offset   (off_q),
      .mem_type (type_q),
      .result   (ext)
   );

   always_comb begin
      size_in    = decode_size(mem_type);
      misaligned = ((size_in == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                   ((size_in == SZ_HALF) && addr[0]);
      case (size_in)
         SZ_HALF: begin
            be_in = addr[1] ? 4'b1100 : 4'b0011;
            wd_in = {2{wdata[15:0]}};
         end
         SZ_BYTE: begin
            be_in = 4'b0001 << addr[1:0];
            wd_in = {4{wdata[7:0]}};
         end
         default: begin
            be_in = 4'b1111;
            wd_in = wdata;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      busy       = (state != S_IDLE);
      done       = (state == S_FIN) || (state == S_ERR);
      misalign   = (state == S_ERR) && !err_to;
      timeout    = (state == S_ERR) && err_to;
      case (state)
         S_IDLE: if (start) state_next = misaligned ? S_ERR : S_REQ;
         // Ack takes priority over the timeout limit in the same cycle.
         S_REQ: begin
            if (mem_ack)               state_next = S_FIN;
            else if (cnt == LAST_CNT)  state_next = S_ERR;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         is_store_q <= 1'b0;
         type_q     <= '0;
         off_q      <= '0;
         err_to     <= 1'b0;
         rdata      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state   <= state_next;
         mem_req <= (state_next == S_REQ);
         case (state)
            S_IDLE: if (start) begin
               is_store_q <= is_store;
               type_q     <= mem_type;
               off_q      <= addr[1:0];
               cnt        <= '0;
               err_to     <= 1'b0;
               mem_addr   <= {addr[31:2], 2'b00};
               mem_we     <= is_store && !misaligned;
               mem_be     <= be_in;
               mem_wdata  <= wd_in;
            end
            S_REQ: begin
               if (mem_ack) begin
                  if (!is_store_q) rdata <= ext;
                  mem_we <= 1'b0;
               end else if (cnt == LAST_CNT) begin
                  err_to <= 1'b1;
                  mem_we <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl, built with TIMEOUT = 4.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, is_store;
   logic [2:0]  mem_type;
   logic [31:0] addr, wdata;
   logic        busy, done, misalign, timeout;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_store  (is_store),
      .mem_type  (mem_type),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .misalign  (misalign),
      .timeout   (timeout),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, let edge 0 sample it, then drop start.
   task automatic issue(input logic st, input logic [2:0] mt,
                        input logic [31:0] a, input logic [31:0] wd);
      is_store = st; mem_type = mt; addr = a; wdata = wd; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({done, busy, misalign, timeout, mem_req, mem_we, mem_be} !== 10'd0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0", {done, busy, misalign, timeout, mem_req, mem_we, mem_be});
      end
      checks++;
      if ({mem_addr, mem_wdata, rdata} !== 96'd0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h expected 0", mem_addr, mem_wdata, rdata);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_store_word();
      issue(1'b1, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF);
      checks++;
      if ({mem_req, mem_we, busy, done} !== 4'b1110) begin
         errors++;
         $display("FAIL sw_req: got req/we/busy/done=%b expected 1110", {mem_req, mem_we, busy, done});
      end
      checks++;
      if ({mem_addr, mem_be, mem_wdata} !== {32'h0000_0100, 4'b1111, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL sw_bus: got addr=%h be=%b wd=%h expected 00000100 1111 deadbeef", mem_addr, mem_be, mem_wdata);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({done, misalign, timeout, mem_req} !== 4'b1000) begin
         errors++;
         $display("FAIL sw_done: got done/mis/to/req=%b expected 1000", {done, misalign, timeout, mem_req});
      end
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL sw_idle: got done/busy=%b expected 00", {done, busy});
      end
   endtask

   task automatic test_load_byte(input logic [2:0] mt, input logic [31:0] exp);
      issue(1'b0, mt, 32'h0000_0203, 32'h0);
      mem_rdata = 32'h8012_3456;
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'b1000, 32'h0000_0200}) begin
         errors++;
         $display("FAIL lb_bus: got req=%b we=%b be=%b addr=%h expected 1 0 1000 00000200", mem_req, mem_we, mem_be, mem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({mem_req, done} !== 2'b10) begin
            errors++;
            $display("FAIL lb_wait%0d: got req/done=%b expected 10", i, {mem_req, done});
         end
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({done, timeout, rdata} !== {2'b10, exp}) begin
         errors++;
         $display("FAIL lb_done: got done=%b to=%b rdata=%h expected 1 0 %h", done, timeout, rdata, exp);
      end
      tick();
   endtask

   task automatic test_store_half();
      issue(1'b1, 3'd1, 32'h0000_0012, 32'h0000_ABCD);
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, 4'b1100, 32'h0000_0010, 32'hABCD_ABCD}) begin
         errors++;
         $display("FAIL sh_bus: got req=%b we=%b be=%b addr=%h wd=%h expected 1 1 1100 00000010 abcdabcd", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL sh_done: got %b expected 1", done);
      end
      tick();
   endtask

   task automatic test_misalign();
      issue(1'b0, 3'd0, 32'h0000_0101, 32'h0);
      checks++;
      if ({done, misalign, timeout, mem_req, busy} !== 5'b11001) begin
         errors++;
         $display("FAIL mis_flags: got done/mis/to/req/busy=%b expected 11001", {done, misalign, timeout, mem_req, busy});
      end
      tick();
      checks++;
      if ({done, mem_req, busy, rdata} !== {3'b000, 32'h0000_0080}) begin
         errors++;
         $display("FAIL mis_after: got done=%b req=%b busy=%b rdata=%h expected 0 0 0 00000080", done, mem_req, busy, rdata);
      end
   endtask

   task automatic test_timeout();
      issue(1'b0, 3'd1, 32'h0000_0002, 32'h0);
      mem_rdata = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({mem_req, done} !== 2'b10) begin
            errors++;
            $display("FAIL to_req%0d: got req/done=%b expected 10", i, {mem_req, done});
         end
         if (i < 3) tick();
      end
      tick();
      checks++;
      if ({done, timeout, misalign, mem_req, rdata} !== {4'b1100, 32'h0000_0080}) begin
         errors++;
         $display("FAIL to_err: got done=%b to=%b mis=%b req=%b rdata=%h expected 1 1 0 0 00000080", done, timeout, misalign, mem_req, rdata);
      end
      tick();
   endtask

   task automatic test_ack_at_limit();
      issue(1'b0, 3'd1, 32'h0000_0002, 32'h0);
      mem_rdata = 32'h8001_0000;
      tick();
      tick();
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({done, timeout, rdata} !== {2'b10, 32'hFFFF_8001}) begin
         errors++;
         $display("FAIL ack_limit: got done=%b to=%b rdata=%h expected 1 0 ffff8001", done, timeout, rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic seen_done = 1'b0;
      issue(1'b0, 3'd0, 32'h0000_0300, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, busy, rdata} !== {2'b00, 32'h0}) begin
         errors++;
         $display("FAIL rst_mid: got req=%b busy=%b rdata=%h expected 0 0 00000000", mem_req, busy, rdata);
      end
      tick();
      rst_n = 1'b1;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done || mem_req) seen_done = 1'b1;
         tick();
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_nodone: got activity=%b expected 0", seen_done);
      end
   endtask

   task automatic test_start_while_busy();
      logic extra = 1'b0;
      issue(1'b1, 3'd0, 32'h0000_0040, 32'h1111_2222);
      is_store = 1'b0; addr = 32'h0000_0444; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h0000_0040, 32'h1111_2222}) begin
         errors++;
         $display("FAIL busy_hold: got req=%b we=%b addr=%h wd=%h expected 1 1 00000040 11112222", mem_req, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL busy_done: got %b expected 1", done);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_req || busy || done) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++;
         $display("FAIL busy_noqueue: got second access=%b expected 0", extra);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mem_type = '0;
      addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_store_word();
      test_load_byte(3'd3, 32'hFFFF_FF80);
      test_load_byte(3'd4, 32'h0000_0080);
      test_store_half();
      test_misalign();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid();
      test_start_while_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store sequencer between the CPU control FSM and the data memory port. It accepts one access request and checks alignment. It then drives a word-aligned memory request with byte enables and holds it until acknowledge or timeout. Loaded data is returned sign/zero-extended. It sits in the datapath between the ALU address result and the memory data register, and replaces ad-hoc memory strobes from the main controller.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` is held without `mem_ack` before the access aborts; 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  access request; sampled in IDLE only.
- `is_store`  in  1  1 = store, 0 = load.
- `mem_type`  in  3  access size/extension code: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; codes 5–7 are treated as word. For stores, LH/LHU mean half and LB/LBU mean byte.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data, right-justified.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; holds until the next load completes.
- `misalign`  out  1  valid with `done`; address not aligned to the access size.
- `timeout`  out  1  valid with `done`; no `mem_ack` within `TIMEOUT` cycles.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  32  `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory acknowledge; single-cycle pulse.
- `mem_rdata`  in  32  read word; valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, FIN, ERR.
- **IDLE:** on `start`, latch `is_store`, `mem_type`, `addr`, `wdata`.
  - Aligned access: go to REQ.
  - Misaligned access (word with `addr[1:0]`≠0, half with `addr[0]`≠0): go to ERR with `misalign` set. No `mem_req` is issued.
- **REQ:** `mem_req`=1 and memory outputs stay stable.
  - On `mem_ack`: capture and extend read data for a load, then go to FIN.
  - Else, when the wait counter reaches `TIMEOUT`-1: go to ERR with `timeout` set.
  - If `mem_ack` arrives in the same cycle the counter reaches its limit, the ack wins.
- **FIN:** `done`=1 for one cycle, then IDLE.
- **ERR:** `done`=1 with the error flag set for one cycle, then IDLE. `rdata` is unchanged.
- `start` outside IDLE is ignored. It is not queued.
- Byte enables:
  - Word: 1111.
  - Half: 0011 if `addr[1]`=0, else 1100.
  - Byte: 0001 shifted left by `addr[1:0]`.
- Store data lanes: byte replicated ×4, half replicated ×2, word passed through.
- Load extraction selects the lane by `addr[1:0]`. It sign-extends for LH/LB and zero-extends for LHU/LBU; word passes through.
- `mem_be` is also driven on loads; the memory may ignore it.

## Timing
- Reset value of every output is 0, `rdata` included. State goes to IDLE and the counter clears.
- Reset asserted mid-access drops `mem_req` immediately (asynchronously), and no `done` is produced.
- `start` sampled at edge 0 → `mem_req` high after edge 0. `mem_ack` sampled at edge k → `done` high after edge k.
- Minimum latency is 2 cycles from `start` to `done`, with a zero-wait ack.
- Misaligned access: `done`+`misalign` in the cycle after `start`.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then one ERR cycle.
- `mem_*` outputs are registered. `done`, `misalign`, `timeout` and `busy` are decoded from the registered state.
- `rdata` updates on the same edge that enters FIN.

## Structure
- Shared package `mem_pkg`:
  - `mem_type` code constants (LW, LH, LHU, LB, LBU).
  - State encoding typedef.
  - Size-decode function (word/half/byte).
- Sub-module `load_extract` (combinational lane select + extension), instantiated on the `mem_rdata` path ahead of the capture register.
- Byte-enable and store-lane logic stays inline.

## Test plan
- SW, `addr`=0x100, `wdata`=0xDEADBEEF, ack on the 1st REQ cycle → `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `done` 2 cycles after `start`.
- LB, `addr`=0x203, `mem_rdata`=0x80123456, ack after 3 waits → `rdata`=0xFFFFFF80; repeat with LBU → 0x00000080; `done` 5 cycles after `start`.
- SH, `addr`=0x12, `wdata`=0x0000ABCD → `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x10.
- LW, `addr`=0x101 → `done`+`misalign` in the next cycle, `mem_req` never asserted, `rdata` unchanged.
- LH, `TIMEOUT`=4, no ack → `mem_req` high for 4 cycles then `done`+`timeout`. Second run with ack in the 4th cycle → normal FIN, `timeout`=0.
- Assert `rst_n` low during REQ → `mem_req`=0 immediately, no `done`. A `start` pulse while busy produces no second access.
